// File: rtl/regarb_pkg.sv
// Shared definitions for the register-file write arbiter and its round-robin picker.
package regarb_pkg;

  localparam int REGARB_ADDR_W  = 5;
  localparam int REGARB_DATA_W  = 32;
  localparam int REGARB_MAX_REQ = 4;
  localparam int REGARB_PTR_W   = 2;

  localparam logic [REGARB_ADDR_W-1:0] REGARB_ZERO_REG = 5'd0;

  typedef logic [REGARB_PTR_W-1:0] rr_ptr_t;

  // Pointer moves just past the winner; an out-of-range index leaves it where it was.
  function automatic rr_ptr_t rr_next(input rr_ptr_t ptr, input rr_ptr_t grant_idx,
                                      input int unsigned n);
    int unsigned nxt;
    if (32'(grant_idx) >= n) return ptr;
    nxt = 32'(grant_idx) + 32'd1;
    if (nxt >= n) nxt = 0;
    return rr_ptr_t'(nxt);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first valid requester at or after the pointer wins.
module rr_priority_picker
  import regarb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  rr_ptr_t            ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output rr_ptr_t            grant_idx_o,
  output logic               grant_any_o
);

  logic [REGARB_MAX_REQ-1:0] valid_ext;
  logic [REGARB_PTR_W:0]     pos;

  assign valid_ext = REGARB_MAX_REQ'(req_valid_i);

  // ptr_i is always below NUM_REQ, so one conditional subtract implements the modulo.
  always_comb begin
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    pos         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr_i} + (REGARB_PTR_W+1)'(k);
      if (pos >= (REGARB_PTR_W+1)'(NUM_REQ)) pos = pos - (REGARB_PTR_W+1)'(NUM_REQ);
      if (!grant_any_o && valid_ext[pos[REGARB_PTR_W-1:0]]) begin
        grant_idx_o = pos[REGARB_PTR_W-1:0];
        grant_any_o = 1'b1;
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      grant_o[j] = grant_any_o && (grant_idx_o == REGARB_PTR_W'(j));
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ sources.
// Optional macro REGARB_HAZARD_EN adds read-vs-staged-write hazard flags.
module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REGARB_ADDR_W,
  parameter int DATA_W  = REGARB_DATA_W
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      Flush,
  input  logic [NUM_REQ-1:0]        ReqValid,
  output logic [NUM_REQ-1:0]        ReqReady,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] ReqData,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         WriteRegister,
  output logic [DATA_W-1:0]         WriteData
`ifdef REGARB_HAZARD_EN
  ,
  input  logic [ADDR_W-1:0]         ReadRegister1,
  input  logic [ADDR_W-1:0]         ReadRegister2,
  output logic                      Hazard1,
  output logic                      Hazard2
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > REGARB_MAX_REQ) begin : g_bad_num_req
    $error("regfile_write_arbiter: NUM_REQ must be in 2..4");
  end

  logic [NUM_REQ-1:0] grant;
  rr_ptr_t            grant_idx;
  logic               grant_any;
  logic               transfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  rr_ptr_t            ptr_q, ptr_d;
  logic               regwrite_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [DATA_W-1:0]  wdata_q;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid_i (ReqValid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  // Ready is also held low while in reset so nothing appears accepted during it.
  assign transfer = grant_any & ~Flush & Reset_n;
  assign ReqReady = transfer ? grant : '0;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_addr = ReqAddr[k*ADDR_W +: ADDR_W];
        sel_data = ReqData[k*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_d = transfer ? rr_next(ptr_q, grant_idx, NUM_REQ) : ptr_q;

  // Output stage: writes to r0 are accepted and latched but never enabled.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q      <= '0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      regwrite_q <= transfer && (sel_addr != ADDR_W'(REGARB_ZERO_REG));
      if (transfer) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
    end
  end

  assign RegWrite      = regwrite_q;
  assign WriteRegister = waddr_q;
  assign WriteData     = wdata_q;

`ifdef REGARB_HAZARD_EN
  assign Hazard1 = regwrite_q && (waddr_q == ReadRegister1) &&
                   (ReadRegister1 != ADDR_W'(REGARB_ZERO_REG));
  assign Hazard2 = regwrite_q && (waddr_q == ReadRegister2) &&
                   (ReadRegister2 != ADDR_W'(REGARB_ZERO_REG));
`endif

endmodule
